// File: rtl/pipe_stage_buffer_if.sv
// Handshake bundle for pipe_stage_buffer: upstream valid/ready/payload,
// downstream valid/ready/payload, hazard/redirect controls and occupancy.
interface pipe_stage_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 27
);
  logic              flush;
  logic              bubble;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  // master drives the stage (upstream producer + downstream consumer side)
  modport master (
    output flush, bubble, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  flush, bubble, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Registered pipeline stage boundary with a 2-entry (head + skid) buffer,
// valid/ready handshake, hazard bubble insertion and synchronous flush.
module pipe_stage_buffer #(
  parameter int              DATA_W      = 32,
  parameter int              CTRL_W      = 27,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input logic            clk,
  input logic            reset,
  pipe_stage_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] head_data, skid_data, wr_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, wr_ctrl;
  logic              in_ready, out_valid;
  logic              push, bubble_push, push_any, pop;
  logic              head_we, skid_we;

  // Handshake decode; flush discards every push and pop in its cycle.
  always_comb begin
    in_ready    = !reset && !bus.flush && !bus.bubble && (state != S_FULL);
    out_valid   = (state != S_EMPTY);
    push        = bus.in_valid && in_ready;
    bubble_push = bus.bubble && !bus.flush && (state != S_FULL);
    push_any    = push || bubble_push;
    pop         = out_valid && bus.out_ready && !bus.flush;
    wr_data     = bubble_push ? '0 : bus.in_data;
    wr_ctrl     = bubble_push ? BUBBLE_CTRL : bus.in_ctrl;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: if (push_any) state_next = S_ONE;
        S_ONE: begin
          if (push_any && !pop)      state_next = S_FULL;
          else if (!push_any && pop) state_next = S_EMPTY;
        end
        S_FULL:  if (pop) state_next = S_ONE;
        default: state_next = S_EMPTY;
      endcase
    end
  end

  // New entries land in head when it is free (or freed this cycle), else in skid.
  always_comb begin
    head_we = !bus.flush &&
              ((state == S_EMPTY && push_any) ||
               (state == S_ONE   && push_any && pop) ||
               (state == S_FULL  && pop));
    skid_we = !bus.flush && (state == S_ONE) && push_any && !pop;
  end

  // NOTE: payload slots are not reset; the outputs are masked by out_valid,
  // so stale slot contents are never observable.
  always_ff @(posedge clk) begin
    if (head_we) begin
      head_data <= (state == S_FULL) ? skid_data : wr_data;
      head_ctrl <= (state == S_FULL) ? skid_ctrl : wr_ctrl;
    end
    if (skid_we) begin
      skid_data <= wr_data;
      skid_ctrl <= wr_ctrl;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_data  = out_valid ? head_data : '0;
    bus.out_ctrl  = out_valid ? head_ctrl : BUBBLE_CTRL;
    bus.occupancy = state;
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed testbench for pipe_stage_buffer: inputs driven 1 time unit after
// the rising edge, outputs sampled on the falling edge.
module tb_pipe_stage_buffer;
  localparam int              DATA_W = 32;
  localparam int              CTRL_W = 27;
  localparam logic [CTRL_W-1:0] BUB  = 27'h5A5A5;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_stage_buffer_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_CTRL(BUB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [26:0] c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0; bus.bubble = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #2;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.out_ctrl !== BUB) begin n_err++; $display("FAIL rst_out_ctrl got=%h exp=%h", bus.out_ctrl, BUB); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    next_cycle();
    next_cycle();
    reset = 1'b0;
    // plan 1: single entry passes with one cycle latency
    drive(1'b1, 32'h13, 27'h0A5);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t1_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t1_pre_valid got=%b exp=0", bus.out_valid); end
    next_cycle();
    drive(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL t1_out_valid got=%b exp=1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h13) begin n_err++; $display("FAIL t1_out_data got=%h exp=13", bus.out_data); end
    n_cmp++; if (bus.out_ctrl !== 27'h0A5) begin n_err++; $display("FAIL t1_out_ctrl got=%h exp=0a5", bus.out_ctrl); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_err++; $display("FAIL t1_occ got=%0d exp=1", bus.occupancy); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL t1_drain got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_skid();
    next_cycle();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 27'h1);
    next_cycle();
    drive(1'b1, 32'h22, 27'h2);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready_b got=%b exp=1", bus.in_ready); end
    next_cycle();
    drive(1'b1, 32'h33, 27'h3);
    @(negedge clk);
    n_cmp++; if (bus.occupancy !== 2'd2) begin n_err++; $display("FAIL t2_occ_full got=%0d exp=2", bus.occupancy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t2_ready_full got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.out_data !== 32'h11) begin n_err++; $display("FAIL t2_head_a got=%h exp=11", bus.out_data); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 32'h11 || bus.out_ctrl !== 27'h1) begin n_err++; $display("FAIL t2_stall_hold got=%h/%h exp=11/1", bus.out_data, bus.out_ctrl); end
    n_cmp++; if (bus.occupancy !== 2'd2) begin n_err++; $display("FAIL t2_stall_occ got=%0d exp=2", bus.occupancy); end
    bus.out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 32'h22 || bus.out_ctrl !== 27'h2) begin n_err++; $display("FAIL t2_head_b got=%h/%h exp=22/2", bus.out_data, bus.out_ctrl); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_err++; $display("FAIL t2_occ_b got=%0d exp=1", bus.occupancy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready_c got=%b exp=1", bus.in_ready); end
    next_cycle();
    drive(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 32'h33 || bus.out_ctrl !== 27'h3) begin n_err++; $display("FAIL t2_head_c got=%h/%h exp=33/3", bus.out_data, bus.out_ctrl); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_err++; $display("FAIL t2_occ_c got=%0d exp=1", bus.occupancy); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t2_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_bubble();
    next_cycle();
    bus.out_ready = 1'b1;
    bus.bubble = 1'b1;
    drive(1'b1, 32'h55, 27'h55);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t3_ready got=%b exp=0", bus.in_ready); end
    next_cycle();
    bus.bubble = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL t3_bub_valid got=%b exp=1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL t3_bub_data got=%h exp=0", bus.out_data); end
    n_cmp++; if (bus.out_ctrl !== BUB) begin n_err++; $display("FAIL t3_bub_ctrl got=%h exp=%h", bus.out_ctrl, BUB); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t3_ready2 got=%b exp=1", bus.in_ready); end
    next_cycle();
    drive(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 32'h55 || bus.out_ctrl !== 27'h55) begin n_err++; $display("FAIL t3_after got=%h/%h exp=55/55", bus.out_data, bus.out_ctrl); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_err++; $display("FAIL t3_occ got=%0d exp=1", bus.occupancy); end
    next_cycle();
  endtask

  task automatic fill_two();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 27'h1);
    next_cycle();
    drive(1'b1, 32'h22, 27'h2);
    next_cycle();
    drive(1'b0, '0, '0);
  endtask

  task automatic test_flush();
    fill_two();
    // bubble while full must be ignored
    bus.bubble = 1'b1;
    next_cycle();
    bus.bubble = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.occupancy !== 2'd2 || bus.out_data !== 32'h11) begin n_err++; $display("FAIL t4_full_bubble got=%0d/%h exp=2/11", bus.occupancy, bus.out_data); end
    next_cycle();
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h33, 27'h3);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready got=%b exp=0", bus.in_ready); end
    next_cycle();
    bus.flush = 1'b0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL t4_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin n_err++; $display("FAIL t4_out got=%b/%h exp=0/0", bus.out_valid, bus.out_data); end
    n_cmp++; if (bus.out_ctrl !== BUB) begin n_err++; $display("FAIL t4_ctrl got=%h exp=%h", bus.out_ctrl, BUB); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    fill_two();
    drive(1'b1, 32'h44, 27'h4);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t5_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_ctrl !== BUB) begin n_err++; $display("FAIL t5_ctrl got=%h exp=%h", bus.out_ctrl, BUB); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t5_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL t5_occ got=%0d exp=0", bus.occupancy); end
    next_cycle();
    next_cycle();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t5_ready_rel got=%b exp=1", bus.in_ready); end
    next_cycle();
    drive(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 32'h44 || bus.occupancy !== 2'd1) begin n_err++; $display("FAIL t5_post got=%h/%0d exp=44/1", bus.out_data, bus.occupancy); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 27'(i + 8'h40));
      @(negedge clk);
      if (i > 1) begin
        n_cmp++; if (bus.out_data !== 32'(i - 1) || bus.occupancy !== 2'd1) begin n_err++; $display("FAIL t6_stream_%0d got=%h/%0d exp=%h/1", i, bus.out_data, bus.occupancy, i - 1); end
      end
      next_cycle();
    end
    drive(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 32'h8 || bus.out_ctrl !== 27'h48) begin n_err++; $display("FAIL t6_last got=%h/%h exp=8/48", bus.out_data, bus.out_ctrl); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL t6_drain got=%0d exp=0", bus.occupancy); end
  endtask

  initial begin
    test_reset();
    test_skid();
    test_bubble();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised pipeline stage register for the RISC-V PPU; generalises the combinational control-bubble mux into a registered stage boundary (e.g. ID/EX) with a valid/ready handshake.
- Holds up to two entries (main plus skid), so upstream stalls without a combinational ready path from downstream.
- Supports hazard-driven bubble insertion, where control fields are forced to BUBBLE_CTRL and data to 0.
- Supports a synchronous flush for branch/jump redirect.

Parameters:
DATA_W, 32, width of the datapath payload (operands, PC, immediate concatenated)
CTRL_W, 27, width of the control payload (load/RF/RAM/JAL/JALR/AUIPC flags, ALU op, shift imm, RAM size, op-funct)
BUBBLE_CTRL, 0, control value carried by bubble entries and driven on out_ctrl when out_valid=0

Ports:
clk  in  1  stage clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  synchronous discard of all buffered entries
bubble  in  1  hazard request: insert one bubble entry this cycle instead of accepting input
in_valid  in  1  upstream entry present
in_ready  out  1  stage accepts upstream entry this cycle
in_data  in  DATA_W  upstream datapath payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  head entry present
out_ready  in  1  downstream consumes head entry this cycle
out_data  out  DATA_W  head datapath payload
out_ctrl  out  CTRL_W  head control payload
occupancy  out  2  number of buffered entries (0..2)

Behaviour:
- Storage: 2-entry FIFO (head slot, skid slot); strict in-order.
- Reset (async, any time, including mid-transfer):
  - count=0, occupancy=0, out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL.
  - in_ready=0 while reset is high.
- in_ready = !reset & !flush & !bubble & (count<2).
- Push occurs on in_valid & in_ready.
- Pop occurs on out_valid & out_ready.
- Bubble push occurs on bubble & !flush & (count<2):
  - writes entry {data=0, ctrl=BUBBLE_CTRL}, presented with out_valid=1.
  - upstream entry is NOT consumed (in_ready=0), so it is re-presented later.
  - bubble with count==2: no effect; the hazard source must hold bubble high.
- Latency: a pushed entry is visible on out_* the cycle after push when the FIFO was empty; otherwise it follows earlier entries.
- Count update per rising edge:
  - count += push_any - pop, where push_any = push | bubble push.
  - push and pop allowed in the same cycle: count unchanged; new entry queued behind head.
  - count==2: no push; pop alone -> count=1, skid entry moves to head.
- out_valid = (count!=0).
- out_data/out_ctrl come from the head slot when out_valid=1; otherwise 0 / BUBBLE_CTRL.
- Flush (highest priority after reset):
  - next edge: count=0, out_valid=0.
  - any simultaneous push, bubble push, or pop in that cycle is discarded.
  - in_ready=0 during the flush cycle.
- out_* are stable while out_valid=1 and out_ready=0 (no change to head without pop).
- occupancy mirrors count; value 3 is never produced.
- No width arithmetic beyond the 2-bit count; payloads pass through unmodified except on bubble entries.

Test Plan:
1. After reset release, in_valid=1, in_data=0x0000_0013, in_ctrl=0x0000_0A5, out_ready=1 -> next cycle out_valid=1, out_data=0x13, out_ctrl=0xA5, occupancy=1.
2. out_ready=0; push A=0x11 then B=0x22 -> occupancy=2, in_ready=0. Third entry C=0x33 is held upstream. out_ready=1 -> outputs A, then B, then C on consecutive cycles.
3. bubble=1 for one cycle with in_valid=1, in_data=0x55, count=0 -> in_ready=0. Next cycle out_valid=1, out_data=0, out_ctrl=BUBBLE_CTRL. Following cycle 0x55 is accepted and output after the bubble.
4. count=2 (0x11, 0x22), flush=1 together with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0; no entry (0x11 included) counts as consumed or accepted.
5. Assert reset asynchronously mid-cycle with count=2 -> outputs immediately become out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=0. After release, in_ready=1 on the next edge.
6. Continuous push+pop for 8 cycles with data 0x1..0x8, out_ready=1 -> occupancy stays 1; outputs 0x1..0x8 in order, one cycle behind input.
